// File: rtl/tb_pkg.sv
// Shared constants for the Smith-Waterman traceback walker: matrix geometry,
// move codes, FSM state encodings and the row/column to flat-index helper.
package tb_pkg;

    localparam int unsigned N     = 4;
    localparam int unsigned DIM   = N + 1;
    localparam int unsigned IDX_W = $clog2(DIM * DIM);
    localparam int unsigned RC_W  = $clog2(DIM);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned SW    = 32;

    localparam logic [1:0] MV_DIAG = 2'b00;
    localparam logic [1:0] MV_UP   = 2'b01;
    localparam logic [1:0] MV_LEFT = 2'b10;

    localparam int unsigned ST_W = 4;
    localparam logic [ST_W-1:0] S_IDLE   = 4'd0;
    localparam logic [ST_W-1:0] S_F_CUR  = 4'd1;
    localparam logic [ST_W-1:0] S_CHK    = 4'd2;
    localparam logic [ST_W-1:0] S_F_TOP  = 4'd3;
    localparam logic [ST_W-1:0] S_F_LEFT = 4'd4;
    localparam logic [ST_W-1:0] S_F_DIAG = 4'd5;
    localparam logic [ST_W-1:0] S_CAP    = 4'd6;
    localparam logic [ST_W-1:0] S_EMIT   = 4'd7;
    localparam logic [ST_W-1:0] S_FIN    = 4'd8;

    function automatic logic [IDX_W-1:0] rc_to_idx(input logic [RC_W-1:0] r,
                                                   input logic [RC_W-1:0] c);
        return IDX_W'(r) * IDX_W'(DIM) + IDX_W'(c);
    endfunction

endpackage

// File: rtl/tb_dir_select.sv
// Traceback direction choice from the three neighbour scores (unsigned).
// Diagonal wins all ties, left wins a tie against top.
module tb_dir_select
    import tb_pkg::*;
(
    input  logic [SW-1:0] top,
    input  logic [SW-1:0] left,
    input  logic [SW-1:0] diag,
    output logic [1:0]    mv_code
);

    always_comb begin
        mv_code = MV_DIAG;
        if (diag < top) begin
            mv_code = (top > left) ? MV_UP : MV_LEFT;
        end else if (diag < left) begin
            mv_code = MV_LEFT;
        end
    end

endmodule

// File: rtl/traceback_walker.sv
// Sequential Smith-Waterman traceback: walks from the max-score cell toward
// the origin through the score RAM, emitting one move per step on a valid/ready stream.
module traceback_walker
    import tb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [RC_W-1:0]  start_row,
    input  logic [RC_W-1:0]  start_col,
    input  logic             abort,
    output logic             rd_en,
    output logic [IDX_W-1:0] rd_addr,
    input  logic [SW-1:0]    rd_data,
    output logic             mv_valid,
    input  logic             mv_ready,
    output logic [1:0]       mv_code,
    output logic [IDX_W-1:0] mv_index,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] path_len
);

    logic [ST_W-1:0]  state, state_nxt;
    logic [RC_W-1:0]  row, row_nxt, col, col_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [CNT_W-1:0] step_cnt, step_cnt_nxt;
    logic [SW-1:0]    top_q, top_nxt, left_q, left_nxt;
    logic [1:0]       dir_code_c;

    logic             rd_en_nxt, mv_valid_nxt, busy_nxt, done_nxt;
    logic [IDX_W-1:0] rd_addr_nxt, mv_index_nxt;
    logic [1:0]       mv_code_nxt;
    logic [CNT_W-1:0] path_len_nxt;

    // Diagonal score arrives on rd_data during CAP; decision is latched into mv_code then.
    tb_dir_select u_dir (
        .top     (top_q),
        .left    (left_q),
        .diag    (rd_data),
        .mv_code (dir_code_c)
    );

    always_comb begin
        state_nxt    = state;
        row_nxt      = row;
        col_nxt      = col;
        idx_nxt      = idx;
        step_cnt_nxt = step_cnt;
        top_nxt      = top_q;
        left_nxt     = left_q;
        mv_code_nxt  = mv_code;
        mv_index_nxt = mv_index;
        path_len_nxt = path_len;
        rd_en_nxt    = 1'b0;
        rd_addr_nxt  = '0;

        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    row_nxt      = start_row;
                    col_nxt      = start_col;
                    idx_nxt      = rc_to_idx(start_row, start_col);
                    step_cnt_nxt = '0;
                    path_len_nxt = '0;
                    state_nxt    = S_F_CUR;
                end
            end
            S_F_CUR:  state_nxt = S_CHK;
            S_CHK: begin
                if (row == '0 || col == '0 || rd_data == '0) begin
                    state_nxt = S_FIN;
                end else begin
                    state_nxt = S_F_TOP;
                end
            end
            S_F_TOP:  state_nxt = S_F_LEFT;
            S_F_LEFT: begin
                top_nxt   = rd_data;
                state_nxt = S_F_DIAG;
            end
            S_F_DIAG: begin
                left_nxt  = rd_data;
                state_nxt = S_CAP;
            end
            S_CAP: begin
                mv_code_nxt  = dir_code_c;
                mv_index_nxt = idx;
                state_nxt    = S_EMIT;
            end
            S_EMIT: begin
                if (mv_ready && !abort) begin
                    case (mv_code)
                        MV_UP: begin
                            idx_nxt = idx - IDX_W'(DIM);
                            row_nxt = row - RC_W'(1);
                        end
                        MV_LEFT: begin
                            idx_nxt = idx - IDX_W'(1);
                            col_nxt = col - RC_W'(1);
                        end
                        default: begin
                            idx_nxt = idx - IDX_W'(DIM + 1);
                            row_nxt = row - RC_W'(1);
                            col_nxt = col - RC_W'(1);
                        end
                    endcase
                    step_cnt_nxt = step_cnt + CNT_W'(1);
                    state_nxt    = S_F_CUR;
                end
            end
            S_FIN:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase

        if (abort && state != S_IDLE) begin
            state_nxt = S_IDLE;
        end

        // Outputs are registered images of the state being entered.
        case (state_nxt)
            S_F_CUR: begin
                rd_en_nxt   = 1'b1;
                rd_addr_nxt = idx_nxt;
            end
            S_F_TOP: begin
                rd_en_nxt   = 1'b1;
                rd_addr_nxt = idx_nxt - IDX_W'(DIM);
            end
            S_F_LEFT: begin
                rd_en_nxt   = 1'b1;
                rd_addr_nxt = idx_nxt - IDX_W'(1);
            end
            S_F_DIAG: begin
                rd_en_nxt   = 1'b1;
                rd_addr_nxt = idx_nxt - IDX_W'(DIM + 1);
            end
            default: begin
                rd_en_nxt   = 1'b0;
                rd_addr_nxt = '0;
            end
        endcase

        mv_valid_nxt = (state_nxt == S_EMIT);
        done_nxt     = (state_nxt == S_FIN);
        busy_nxt     = (state_nxt != S_IDLE) && (state_nxt != S_FIN);
        if (done_nxt) begin
            path_len_nxt = step_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            row      <= '0;
            col      <= '0;
            idx      <= '0;
            step_cnt <= '0;
            top_q    <= '0;
            left_q   <= '0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            mv_valid <= 1'b0;
            mv_code  <= '0;
            mv_index <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            path_len <= '0;
        end else begin
            state    <= state_nxt;
            row      <= row_nxt;
            col      <= col_nxt;
            idx      <= idx_nxt;
            step_cnt <= step_cnt_nxt;
            top_q    <= top_nxt;
            left_q   <= left_nxt;
            rd_en    <= rd_en_nxt;
            rd_addr  <= rd_addr_nxt;
            mv_valid <= mv_valid_nxt;
            mv_code  <= mv_code_nxt;
            mv_index <= mv_index_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            path_len <= path_len_nxt;
        end
    end

endmodule

// File: doc/traceback_walker.md
Name: traceback_walker

Overview:
- Sequential traceback controller for the Smith-Waterman scoring matrix.
- Starts at the max-score cell and walks back through the flattened (N+1)x(N+1) score memory. At each step it reads the current, top, left and diagonal scores, picks a direction, and emits one move per step on a valid/ready stream.
- Sits between the score-matrix RAM (read port) and the alignment-string builder (move consumer).

Parameters:
- N, 4: sequence length; the matrix is DIM=N+1 square, row-major, stride DIM.
- IDX_W, 5: flat cell index width, clog2(DIM*DIM).
- RC_W, 3: row/column width, clog2(DIM).
- CNT_W, 4: path length width, holds up to 2N-1.
- SW, 32: score width, unsigned.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a walk when idle.
- start_row  in  RC_W  row of the max-score cell.
- start_col  in  RC_W  column of the max-score cell.
- abort  in  1  synchronous cancel.
- rd_en  out  1  score RAM read strobe.
- rd_addr  out  IDX_W  score RAM address.
- rd_data  in  SW  score; valid the cycle after rd_en.
- mv_valid  out  1  move available.
- mv_ready  in  1  consumer accepts the move.
- mv_code  out  2  00=DIAG, 01=UP, 10=LEFT (11 unused).
- mv_index  out  IDX_W  flat index of the cell the move leaves.
- busy  out  1  walk in progress.
- done  out  1  one-cycle pulse at walk end.
- path_len  out  CNT_W  moves emitted; valid from done, held until next start.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state IDLE; row/col/idx/counters 0. Takes effect immediately, mid-walk included; no done is produced.
- IDLE:
  - start=1 loads row/col and idx=start_row*DIM+start_col, clears the step count, sets busy, clears path_len, then goes to F_CUR.
  - start while busy is ignored.
- F_CUR: rd_en=1, rd_addr=idx, go to CHK.
- CHK: capture cur=rd_data. If row==0 or col==0 or cur==0, go to FIN. Otherwise go to F_TOP.
- F_TOP: read idx-DIM, go to F_LEFT.
- F_LEFT: capture top, read idx-1, go to F_DIAG.
- F_DIAG: capture left, read idx-DIM-1, go to CAP.
- CAP: capture diag, go to EMIT.
- EMIT:
  - mv_valid=1. mv_code comes from the direction rule; mv_index=idx.
  - mv_code and mv_index are stable while mv_ready=0; no reads are issued.
  - On mv_valid&mv_ready:
    - DIAG: idx-=DIM+1, row-=1, col-=1.
    - UP: idx-=DIM, row-=1.
    - LEFT: idx-=1, col-=1.
  - Then step_cnt+=1 and go to F_CUR. mv_valid drops the following cycle.
- FIN: done=1 for one cycle, path_len=step_cnt, busy=0, go to IDLE.
- Direction rule (unsigned compares):
  - If diag<top: UP when top>left, else LEFT.
  - Else: LEFT when diag<left, else DIAG.
  - Ties resolve as follows: diag==top==left gives DIAG; top==left>diag gives LEFT.
- Throughput: 7 cycles per move with mv_ready held high. Start to first mv_valid takes 6 cycles.
- Underflow: the CHK exit guarantees idx never goes negative; neighbour reads never run at row 0 or col 0.
- abort=1 in any non-IDLE state: next state IDLE, busy=0, mv_valid=0, rd_en=0, no done, path_len unchanged. abort has priority over a simultaneous mv_ready handshake. Concurrent start and abort in IDLE: abort wins.
- rd_en is 0 in IDLE, CAP, EMIT and FIN.

Decomposition:
- Shared package tb_pkg holds:
  - move codes MV_DIAG/MV_UP/MV_LEFT;
  - FSM state enum;
  - the DIM and index-width helper constants.
- One combinational sub-module, tb_dir_select (inputs top/left/diag, output mv_code), implements the direction rule so it can be unit-checked in isolation.

Test Plan:
- Full diagonal walk: RAM score[r][c]=min(r,c), start (4,4), mv_ready=1.
  - Four DIAG moves with mv_index 24,18,12,6.
  - done with path_len=4; then busy=0.
- Direction rule, cur=9, at (2,2):
  - top=6,left=5,diag=4 gives UP, next mv_index 7.
  - top=5,left=5,diag=4 gives LEFT.
  - top=3,left=6,diag=5 gives LEFT.
  - all =5 gives DIAG.
- Zero start: score at (3,2)=0, start (3,2).
  - rd_addr 17 read once, no mv_valid.
  - done 2 cycles after start, path_len=0.
- Edge start: start (0,3).
  - done with path_len=0; no neighbour reads (rd_addr never 2).
- Backpressure: mv_ready=0 for 5 cycles during the first move.
  - mv_valid held, mv_code/mv_index stable, rd_en=0.
  - On release, exactly one move is accepted; the final path_len is unchanged versus the no-stall run.
- Abort/reset:
  - abort in F_LEFT gives IDLE next cycle with no done.
  - rst_n low mid-EMIT clears mv_valid/busy asynchronously before the next edge.
  - start during busy is ignored.
